// File: rtl/uart_hex_pkg.sv
// Shared ASCII constants, byte classes and hex helpers for the UART hex loader.
package uart_hex_pkg;

   localparam logic [7:0] COLON = 8'h3A;
   localparam logic [7:0] SPACE = 8'h20;
   localparam logic [7:0] TAB   = 8'h09;
   localparam logic [7:0] LF    = 8'h0A;
   localparam logic [7:0] CR    = 8'h0D;

   typedef enum logic [1:0] {CLS_HEX, CLS_WS, CLS_SYNC, CLS_BAD} byte_class_t;

   function automatic logic is_hex(input logic [7:0] b);
      return (b >= 8'h30 && b <= 8'h39) ||
             (b >= 8'h41 && b <= 8'h46) ||
             (b >= 8'h61 && b <= 8'h66);
   endfunction

   // Letters share their low nibble between cases ('A'=0x41, 'a'=0x61), so +9 maps both to 10..15.
   function automatic logic [3:0] hex_val(input logic [7:0] b);
      if (b >= 8'h30 && b <= 8'h39)
         return b[3:0];
      else if (is_hex(b))
         return 4'(b[3:0] + 4'd9);
      else
         return 4'h0;
   endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational classifier: splits a received byte into hex / whitespace / resync / bad.
module hex_ascii_decode
   import uart_hex_pkg::*;
(
   input  logic [7:0]  data,
   output byte_class_t byte_class,
   output logic [3:0]  nibble
);

   always_comb begin
      byte_class = CLS_BAD;
      nibble     = 4'h0;
      if (is_hex(data)) begin
         byte_class = CLS_HEX;
         nibble     = hex_val(data);
      end else if (data == SPACE || data == TAB || data == LF || data == CR) begin
         byte_class = CLS_WS;
      end else if (data == COLON) begin
         byte_class = CLS_SYNC;
      end
   end

endmodule

// File: rtl/uart_hex_loader.sv
// UART ASCII-hex loader: assembles DATA_W-bit words into instruction memory and echoes bytes.
// Optional checksum output enabled by defining UART_HEX_LOADER_CSUM_EN.
module uart_hex_loader
   import uart_hex_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ECHO   = 1,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic              done,
   output logic              err,
   output logic [3:0]        last_nib,
   output logic [7:0]        csum
);

   localparam int NIB   = DATA_W / 4;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   logic              run_q;
   logic [CNT_W-1:0]  nib_cnt;
   logic [DATA_W-1:0] shift_q;
   logic [ADDR_W-1:0] wr_ptr;
   byte_class_t       byte_class;
   logic [3:0]        nibble;
   logic              accept;
   logic              decode;
   logic              commit;
   logic [DATA_W-1:0] next_word;

   hex_ascii_decode u_decode (
      .data       (rx_data),
      .byte_class (byte_class),
      .nibble     (nibble)
   );

   // With echo enabled the single tx register doubles as the input buffer.
   assign rx_ready  = (ECHO != 0) ? (run_q && !tx_valid) : run_q;
   assign accept    = rx_valid && rx_ready;
   assign decode    = accept && load_en;
   assign next_word = DATA_W'({shift_q, nibble});
   assign commit    = decode && (byte_class == CLS_HEX) && !done && (nib_cnt == CNT_W'(NIB - 1));
   assign done      = (word_count == (ADDR_W + 1)'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q    <= 1'b0;
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         run_q <= 1'b1;
         if (ECHO != 0) begin
            if (accept) begin
               tx_valid <= 1'b1;
               tx_data  <= rx_data;
            end else if (tx_ready) begin
               tx_valid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nib_cnt    <= '0;
         shift_q    <= '0;
         wr_ptr     <= '0;
         word_count <= '0;
         err        <= 1'b0;
         last_nib   <= 4'h0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         mem_we <= 1'b0;
         if (decode) begin
            case (byte_class)
               CLS_HEX: begin
                  if (done) begin
                     err <= 1'b1;
                  end else begin
                     shift_q  <= next_word;
                     last_nib <= nibble;
                     if (commit) begin
                        nib_cnt    <= '0;
                        mem_we     <= 1'b1;
                        mem_addr   <= wr_ptr;
                        mem_wdata  <= next_word;
                        word_count <= word_count + (ADDR_W + 1)'(1);
                        // Pointer parks on the last address once the memory fills.
                        if (word_count != (ADDR_W + 1)'(DEPTH - 1))
                           wr_ptr <= wr_ptr + ADDR_W'(1);
                     end else begin
                        nib_cnt <= nib_cnt + CNT_W'(1);
                     end
                  end
               end
               CLS_SYNC: begin
                  nib_cnt    <= '0;
                  wr_ptr     <= '0;
                  word_count <= '0;
                  err        <= 1'b0;
               end
               CLS_BAD: begin
                  err     <= 1'b1;
                  nib_cnt <= '0;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef UART_HEX_LOADER_CSUM_EN
   localparam int NB = (NIB + 1) / 2;

   logic [NB*8-1:0] padded;
   logic [7:0]      word_sum;
   logic [7:0]      csum_q;

   assign padded = (NB * 8)'(next_word);

   always_comb begin
      word_sum = 8'h00;
      for (int i = 0; i < NB; i++)
         word_sum = word_sum + padded[i*8 +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         csum_q <= 8'h00;
      else if (commit)
         csum_q <= csum_q + word_sum;
      else if (decode && byte_class == CLS_SYNC)
         csum_q <= 8'h00;
   end

   assign csum = csum_q;
`else
   assign csum = 8'h00;
`endif

endmodule
